// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier (and later the divider).
// Helpers work at 64 bits; callers sign-extend on entry and slice on exit.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    EPILOGUE
  } state_t;

  localparam int unsigned HelperWidth = 64;

  // Two's-complement magnitude; the most-negative value maps to its unsigned magnitude.
  function automatic logic [HelperWidth-1:0] abs_mag(input logic signed [HelperWidth-1:0] v);
    return v[HelperWidth-1] ? HelperWidth'(-v) : HelperWidth'(v);
  endfunction

  function automatic logic [HelperWidth-1:0] apply_sign(input logic [HelperWidth-1:0] mag,
                                                        input logic neg);
    return neg ? (~mag + HelperWidth'(1)) : mag;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative signed shift-add multiplier, one product per B_WIDTH+2 cycles.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult
  import mult_pkg::*;
#(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8,
  localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic signed [A_WIDTH-1:0] multiplicand,
  input  logic signed [B_WIDTH-1:0] multiplier,
  output logic                      ready,
  output logic signed [P_WIDTH-1:0] product,
  output logic                      valid_out
);

  localparam int CW = $clog2(B_WIDTH + 1);

  state_t             state;
  logic [P_WIDTH-1:0] acc;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  logic [CW-1:0]      count;
  logic               sign;

  logic [63:0]        a_abs_w, b_abs_w, prod_w;
  logic [A_WIDTH-1:0] a_mag_in;
  logic [B_WIDTH-1:0] b_mag_in;
  logic [P_WIDTH-1:0] acc_next;
  logic [P_WIDTH-1:0] prod_next;
  logic               last_iter;
  logic               unused_bits;

  always_comb begin
    a_abs_w   = abs_mag(64'(multiplicand));
    b_abs_w   = abs_mag(64'(multiplier));
    a_mag_in  = a_abs_w[A_WIDTH-1:0];
    b_mag_in  = b_abs_w[B_WIDTH-1:0];
    acc_next  = acc;
    if (b_mag[0]) begin
      acc_next = acc + (P_WIDTH'(a_mag) << count);
    end
    prod_w    = apply_sign(64'(acc_next), sign);
    prod_next = prod_w[P_WIDTH-1:0];
    last_iter = (count == CW'(B_WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
    last_iter = last_iter || ((b_mag >> 1) == '0);
`endif
  end

  assign unused_bits = ^{a_abs_w[63:A_WIDTH], b_abs_w[63:B_WIDTH], prod_w[63:P_WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      product   <= '0;
      acc       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      count     <= '0;
      sign      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (valid_in) begin
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
            sign  <= multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
            acc   <= '0;
            count <= '0;
            ready <= 1'b0;
            state <= LOOP;
`ifdef MULT_EARLY_EXIT_EN
            if (multiplicand == '0 || multiplier == '0) begin
              product   <= '0;
              valid_out <= 1'b1;
              state     <= EPILOGUE;
            end
`endif
          end
        end
        LOOP: begin
          ready <= 1'b0;
          acc   <= acc_next;
          b_mag <= b_mag >> 1;
          count <= count + CW'(1);
          if (last_iter) begin
            product   <= prod_next;
            valid_out <= 1'b1;
            state     <= EPILOGUE;
          end
        end
        EPILOGUE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed table, randomized ops vs. an arithmetic model,
// continuous valid_in, and reset abort. Honours MULT_EARLY_EXIT_EN for expected latency.
module tb_seq_mult;

  localparam int AW = 16;
  localparam int BW = 8;
  localparam int PW = AW + BW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 valid_in = 1'b0;
  logic signed [AW-1:0] multiplicand = '0;
  logic signed [BW-1:0] multiplier = '0;
  logic                 ready;
  logic signed [PW-1:0] product;
  logic                 valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mult #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .ready       (ready),
    .product     (product),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     a;
    int     b;
    longint p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycle (relative to accept) in which valid_out is expected.
  function automatic int exp_lat(input int a, input int b);
`ifdef MULT_EARLY_EXIT_EN
    int mag;
    int hi;
    if (a == 0 || b == 0) return 1;
    mag = (b < 0) ? -b : b;
    hi  = 0;
    for (int i = 0; i < BW; i++) if (mag[i]) hi = i;
    return hi + 2;
`else
    return BW + 1;
`endif
  endfunction

  // Called at a negedge with the DUT idle; issues one op and checks the full response.
  task automatic run_op(input string name, input int a, input int b);
    int lat;
    bit seen;
    check({name, " ready@accept"}, longint'(ready), 1);
    valid_in     = 1'b1;
    multiplicand = AW'(a);
    multiplier   = BW'(b);
    @(negedge clk);
    valid_in     = 1'b0;
    multiplicand = AW'($urandom);
    multiplier   = BW'($urandom);
    lat  = 1;
    seen = 1'b0;
    while (lat <= 3 * BW) begin
      if (ready !== 1'b0) check({name, " ready low while busy"}, longint'(ready), 0);
      if (valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      check({name, " valid_out timeout"}, 0, 1);
    end else begin
      check({name, " latency"}, lat, exp_lat(a, b));
      check({name, " product"}, longint'(product), longint'(a) * longint'(b));
      @(negedge clk);
      check({name, " valid_out single pulse"}, longint'(valid_out), 0);
      check({name, " ready back"}, longint'(ready), 1);
    end
  endtask

  initial begin
    longint exp_q[$];
    int     accept_t[$];
    int     a, b;
    longint held;

    vecs[0] = '{100, 7, 700};
    vecs[1] = '{-300, 5, -1500};
    vecs[2] = '{32767, -128, -4194176};
    vecs[3] = '{-32768, -128, 4194304};
    vecs[4] = '{0, -1, 0};
    vecs[5] = '{1234, 0, 0};
    vecs[6] = '{5, 3, 15};
    vecs[7] = '{5, -128, -640};

    repeat (2) @(negedge clk);
    check("reset ready", longint'(ready), 1);
    check("reset valid_out", longint'(valid_out), 0);
    check("reset product", longint'(product), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      check($sformatf("vec%0d table model", i), vecs[i].p, longint'(vecs[i].a) * longint'(vecs[i].b));
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
    end

    held = longint'(product);
    repeat (3) @(negedge clk);
    check("product held", longint'(product), held);

    for (int i = 0; i < 30; i++) begin
      a = int'($signed(AW'($urandom)));
      b = int'($signed(BW'($urandom)));
      if (i % 10 == 0) b = -128;
      if (i % 10 == 1) a = -32768;
      run_op($sformatf("rand%0d", i), a, b);
    end

    // valid_in held high with fresh operands every cycle
    for (int t = 0; t < 60; t++) begin
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) check("held stray valid_out", 1, 0);
        else check("held product", longint'(product), exp_q.pop_front());
      end
      valid_in     = 1'b1;
      a            = int'($signed(AW'($urandom)));
      b            = int'($signed(BW'($urandom)));
      multiplicand = AW'(a);
      multiplier   = BW'(b);
      if (ready === 1'b1) begin
        exp_q.push_back(longint'(a) * longint'(b));
        accept_t.push_back(t);
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    for (int t = 0; t < 3 * BW && exp_q.size() > 0; t++) begin
      if (valid_out === 1'b1) check("held product drain", longint'(product), exp_q.pop_front());
      @(negedge clk);
    end
    check("held queue drained", exp_q.size(), 0);
    check("held accept count nonzero", longint'(accept_t.size() >= 3), 1);
`ifndef MULT_EARLY_EXIT_EN
    for (int i = 1; i < accept_t.size(); i++)
      check("held accept spacing", accept_t[i] - accept_t[i-1], BW + 2);
`endif
    repeat (2) @(negedge clk);

    // reset in the middle of LOOP aborts the op
    valid_in     = 1'b1;
    multiplicand = AW'(1000);
    multiplier   = BW'(-77);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort ready", longint'(ready), 1);
    check("abort valid_out", longint'(valid_out), 0);
    check("abort product", longint'(product), 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after abort", 12, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Iterative signed shift-add multiplier. It is the inverse companion of the team's iterative divider, used in the canny edge detection datapath.
- Typical uses are gradient scaling and fixed-point weight products.
- It uses the same single-cycle valid_in / valid_out pulse handshake as the divider, and adds a ready output so upstream logic knows when an operand pair will be taken.
- Computes one product per B_WIDTH+2 cycles with fixed latency.

Parameters:
- A_WIDTH, 16, multiplicand width (signed two's complement)
- B_WIDTH, 8, multiplier width (signed two's complement); sets the loop count
- P_WIDTH, A_WIDTH+B_WIDTH, product width (localparam, not overridable)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  operand pair valid; sampled only while ready=1
- multiplicand  input  A_WIDTH  signed operand a
- multiplier  input  B_WIDTH  signed operand b
- ready  output  1  high in IDLE only; a valid_in pulse while ready=0 is dropped
- product  output  P_WIDTH  signed a*b; registered, held until the next result
- valid_out  output  1  one-cycle pulse, product is valid

Behaviour:
- Reset (asynchronous, active-high, on clk domain):
  - state=IDLE, ready=1, valid_out=0, product=0.
  - All internal registers (acc, a_mag, b_mag, count, sign) are cleared to 0.
- Reset mid-operation aborts the operation. No valid_out is issued for the aborted operation, and the next accept is allowed in the first cycle after reset deasserts.
- State machine (enum):
  - IDLE: ready=1. On valid_in=1, latch the following, then go to LOOP:
    - a_mag = |multiplicand|, unsigned, A_WIDTH bits
    - b_mag = |multiplier|, unsigned, B_WIDTH bits
    - sign = msb(a) XOR msb(b)
    - acc = 0, count = 0
  - IDLE with valid_in=0: stay in IDLE.
  - LOOP: ready=0. Each cycle:
    - if b_mag[0]=1, acc += a_mag << count, computed at P_WIDTH unsigned;
    - b_mag >>= 1; count++.
    - After the LOOP cycle with count==B_WIDTH-1, load product = sign ? -acc : acc (P_WIDTH two's complement) and go to EPILOGUE.
  - EPILOGUE: ready=0, valid_out=1 for exactly this cycle, then go to IDLE.
  - Illegal state: go to IDLE with all outputs deasserted.
- Latency and throughput:
  - Let the accept cycle be cycle 0. LOOP occupies cycles 1..B_WIDTH; valid_out is high in cycle B_WIDTH+1 (9 with defaults).
  - Minimum spacing between accepts is B_WIDTH+2 cycles.
- Width and range rules:
  - The magnitude of the most-negative operand is representable in the unsigned magnitude register (-32768 → 0x8000, -128 → 0x80).
  - |a|*|b| ≤ 2^(P_WIDTH-2), so acc never overflows.
  - Most-negative × most-negative = +2^(P_WIDTH-2), which is representable.
  - There is no overflow output.
- Boundary conditions:
  - valid_in held high continuously: one operation is accepted per IDLE visit; inputs are ignored outside IDLE.
  - A zero operand takes the normal full-latency path and yields product=0.
  - Operand inputs are not required to be stable after the accept cycle.
  - product holds its last value between results; it is not cleared on accept.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if either operand is 0, go directly to EPILOGUE with product=0; valid_out is high in cycle 1.
  - In LOOP, if the shifted b_mag becomes 0, finish in that cycle: load product and go to EPILOGUE. Latency becomes (index of highest set bit of |b|)+2 cycles.
- Undefined: fixed latency B_WIDTH+1 for all operands, for deterministic pipeline alignment.

Decomposition:
- Package mult_pkg holds:
  - state_t enum {IDLE, LOOP, EPILOGUE};
  - function abs_mag (two's-complement magnitude);
  - function apply_sign (conditional negate to P_WIDTH).
- No sub-module; a single module is natural. The divider may reuse mult_pkg's abs_mag and apply_sign later.

Test Plan (A_WIDTH=16, B_WIDTH=8, macro undefined unless stated):
1. 100 × 7 → product=0x0002BC (700); valid_out is a single pulse exactly 9 cycles after accept; ready is low for cycles 1..9.
2. -300 × 5 → 0xFFFA24 (-1500); 32767 × -128 → 0xC00080 (-4194176).
3. -32768 × -128 → 0x400000 (+4194304); 0 × -1 → 0x000000 at cycle 9.
4. valid_in held high with new operands every cycle → only the operands present in IDLE are accepted; accepts are spaced 10 cycles apart; each product matches its accepted pair.
5. reset pulsed in LOOP cycle 4 → no valid_out; product=0; ready=1 immediately. 12 × 12 accepted in the next cycle → 0x000090 at cycle 9.
6. MULT_EARLY_EXIT_EN defined:
   - 1234 × 0 → 0 with valid_out at cycle 1;
   - 5 × 3 → 0x00000F at cycle 3;
   - 5 × -128 → 0xFFFD80 (-640) at cycle 9.
